// File: rtl/pcu_pkg.sv
// -----------------------------------------------------------------------------
// pcu_pkg
// Shared types and helpers for the program-counter unit (pcu_fetch_gen).
//   pcu_state_e  : front-end sequencing states (boot, run, halt)
//   step_bytes_f : byte distance between consecutive fetch groups
//   slot_live_f  : per-slot test used to build a group's live-slot mask
// -----------------------------------------------------------------------------
package pcu_pkg;

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } pcu_state_e;

   // Each instruction slot is one 32-bit word.
   function automatic int unsigned step_bytes_f(input int unsigned ways);
      return ways * 32'd4;
   endfunction

   // A slot is live when it is at or above the first slot the target points at.
   function automatic logic slot_live_f(input int unsigned slot, input int unsigned first);
      return (slot >= first);
   endfunction

endpackage

// File: rtl/pcu_redir_arb.sv
// -----------------------------------------------------------------------------
// pcu_redir_arb
// Combinational priority select across the redirect sources; the highest
// requesting index wins.
// Ports:
//   redir_valid_i [REDIR_SRCS]       per-source request
//   redir_addr_i  [REDIR_SRCS*XLEN]  packed targets, source k at [k*XLEN +: XLEN]
//   hit_o                            at least one source is requesting
//   tgt_o         [XLEN]             target of the winning source (0 when no hit)
// -----------------------------------------------------------------------------
module pcu_redir_arb #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned REDIR_SRCS = 2
) (
   input  logic [REDIR_SRCS-1:0]      redir_valid_i,
   input  logic [REDIR_SRCS*XLEN-1:0] redir_addr_i,
   output logic                       hit_o,
   output logic [XLEN-1:0]            tgt_o
);

   // Ascending scan: a later (higher-index) requester overwrites earlier ones.
   always_comb begin
      hit_o = 1'b0;
      tgt_o = {XLEN{1'b0}};
      for (int k = 0; k < int'(REDIR_SRCS); k++) begin
         hit_o = hit_o | redir_valid_i[k];
         tgt_o = redir_valid_i[k] ? redir_addr_i[k*XLEN +: XLEN] : tgt_o;
      end
   end

endmodule

// File: rtl/pcu_fetch_gen.sv
// -----------------------------------------------------------------------------
// pcu_fetch_gen
// Program-counter unit for a FETCH_WAYS-wide front end. Issues one fetch-group
// address per valid/ready handshake, arbitrates redirect sources, buffers a
// redirect that lands while a group is stalled, and tags each group with a
// redirect epoch so downstream stages can drop stale groups.
//
// Optional feature macro: PCU_ALIGN_EN
//   defined   : redirect targets are aligned down to a group boundary and the
//               slots below the target word are masked off for that group.
//   undefined : targets are used raw and slot_mask_o is always all ones.
//
// Ports:
//   clk, reset_n                clock, asynchronous active-low reset
//   ready_i                     fetch stage accepts the current group
//   halt_i                      stop issuing new groups (level)
//   redir_valid_i/redir_addr_i  redirect requests and packed targets
//   valid_o                     pc_o/slot_mask_o/pc_epoch_o valid
//   pc_o                        fetch-group address
//   slot_mask_o                 live instruction slots of the group
//   pc_epoch_o                  epoch the group was issued under
//   cur_epoch_o                 live epoch
//   redir_pend_o                a redirect is buffered and not yet issued
// -----------------------------------------------------------------------------
module pcu_fetch_gen
   import pcu_pkg::*;
#(
   parameter int unsigned     XLEN        = 32,
   parameter int unsigned     FETCH_WAYS  = 2,
   parameter int unsigned     REDIR_SRCS  = 2,
   parameter int unsigned     EPOCH_W     = 3,
   parameter logic [XLEN-1:0] RESET_PC    = {XLEN{1'b0}},
   parameter int unsigned     BOOT_CYCLES = 1
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       ready_i,
   input  logic                       halt_i,
   input  logic [REDIR_SRCS-1:0]      redir_valid_i,
   input  logic [REDIR_SRCS*XLEN-1:0] redir_addr_i,
   output logic                       valid_o,
   output logic [XLEN-1:0]            pc_o,
   output logic [FETCH_WAYS-1:0]      slot_mask_o,
   output logic [EPOCH_W-1:0]         pc_epoch_o,
   output logic [EPOCH_W-1:0]         cur_epoch_o,
   output logic                       redir_pend_o
);

   localparam int unsigned           STEP     = step_bytes_f(FETCH_WAYS);
   localparam logic [XLEN-1:0]       STEP_V   = XLEN'(STEP);
   localparam logic [FETCH_WAYS-1:0] MASK_ALL = {FETCH_WAYS{1'b1}};
   localparam int unsigned           BOOT_W   = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
   localparam logic [BOOT_W-1:0]     BOOT_LAST = BOOT_W'(BOOT_CYCLES - 1);

   // Registered state and outputs
   pcu_state_e                state_r, state_nxt_s;
   logic [BOOT_W-1:0]         boot_cnt_r, boot_cnt_nxt_s;
   logic                      valid_r, valid_nxt_s;
   logic [XLEN-1:0]           pc_r, pc_nxt_s;
   logic [FETCH_WAYS-1:0]     mask_r, mask_nxt_s;
   logic [EPOCH_W-1:0]        pc_epoch_r, pc_epoch_nxt_s;
   logic [EPOCH_W-1:0]        cur_epoch_r, cur_epoch_nxt_s;
   logic                      pend_r, pend_nxt_s;
   logic [XLEN-1:0]           pend_pc_r, pend_pc_nxt_s;
   logic [FETCH_WAYS-1:0]     pend_mask_r, pend_mask_nxt_s;

   // Arbitration and target shaping
   logic                      arb_hit_s;
   logic [XLEN-1:0]           arb_tgt_s;
   logic [XLEN-1:0]           redir_pc_s;
   logic [FETCH_WAYS-1:0]     redir_mask_s;
   logic                      redir_evt_s;
   logic                      hs_s;
   logic [XLEN-1:0]           base_pc_s;

   pcu_redir_arb #(
      .XLEN       (XLEN),
      .REDIR_SRCS (REDIR_SRCS)
   ) u_arb (
      .redir_valid_i (redir_valid_i),
      .redir_addr_i  (redir_addr_i),
      .hit_o         (arb_hit_s),
      .tgt_o         (arb_tgt_s)
   );

`ifdef PCU_ALIGN_EN
   localparam logic [XLEN-1:0] STEP_M = STEP_V - XLEN'(1);
   logic [XLEN-1:0] tgt_off_s;
   int unsigned     first_slot_s;

   // Align the target to its group and mask off the words before it.
   always_comb begin
      tgt_off_s    = arb_tgt_s & STEP_M;
      redir_pc_s   = arb_tgt_s & ~STEP_M;
      first_slot_s = 32'(tgt_off_s >> 2);
      redir_mask_s = {FETCH_WAYS{1'b0}};
      for (int i = 0; i < int'(FETCH_WAYS); i++) begin
         redir_mask_s[i] = slot_live_f(i, first_slot_s);
      end
   end
`else
   assign redir_pc_s   = arb_tgt_s;
   assign redir_mask_s = MASK_ALL;
`endif

   // Next-state / next-output logic for the sequencing FSM and its datapath.
   always_comb begin
      state_nxt_s     = state_r;
      boot_cnt_nxt_s  = boot_cnt_r;
      valid_nxt_s     = valid_r;
      pc_nxt_s        = pc_r;
      mask_nxt_s      = mask_r;
      pc_epoch_nxt_s  = pc_epoch_r;
      pend_nxt_s      = pend_r;
      pend_pc_nxt_s   = pend_pc_r;
      pend_mask_nxt_s = pend_mask_r;

      // Redirects are dropped while booting; otherwise each one opens a new epoch.
      redir_evt_s     = arb_hit_s && (state_r != ST_BOOT);
      cur_epoch_nxt_s = redir_evt_s ? (cur_epoch_r + EPOCH_W'(1)) : cur_epoch_r;
      hs_s            = valid_r && ready_i;
      // After a handshake the sequential successor; with nothing on the bus,
      // pc_r already holds the address of the next group to issue.
      base_pc_s       = hs_s ? (pc_r + STEP_V) : pc_r;

      case (state_r)
         ST_BOOT: begin
            if (boot_cnt_r == BOOT_LAST) begin
               state_nxt_s    = ST_RUN;
               valid_nxt_s    = 1'b1;
               pc_nxt_s       = RESET_PC;
               mask_nxt_s     = MASK_ALL;
               pc_epoch_nxt_s = cur_epoch_r;
            end else begin
               boot_cnt_nxt_s = boot_cnt_r + BOOT_W'(1);
            end
         end

         ST_RUN: begin
            if (valid_r && !ready_i) begin
               // Stalled: the group on the bus is frozen, a redirect is parked.
               if (redir_evt_s) begin
                  pend_nxt_s      = 1'b1;
                  pend_pc_nxt_s   = redir_pc_s;
                  pend_mask_nxt_s = redir_mask_s;
               end else begin
                  pend_nxt_s      = pend_r;
               end
            end else begin
               if (redir_evt_s) begin
                  pc_nxt_s   = redir_pc_s;
                  mask_nxt_s = redir_mask_s;
               end else if (pend_r) begin
                  pc_nxt_s   = pend_pc_r;
                  mask_nxt_s = pend_mask_r;
               end else begin
                  pc_nxt_s   = base_pc_s;
                  mask_nxt_s = MASK_ALL;
               end
               pend_nxt_s     = 1'b0;
               pc_epoch_nxt_s = cur_epoch_nxt_s;
               // Halting keeps the prepared address in pc_r for the restart.
               if (halt_i) begin
                  state_nxt_s = ST_HALT;
                  valid_nxt_s = 1'b0;
               end else begin
                  valid_nxt_s = 1'b1;
               end
            end
         end

         ST_HALT: begin
            if (redir_evt_s) begin
               pc_nxt_s   = redir_pc_s;
               mask_nxt_s = redir_mask_s;
            end else begin
               pc_nxt_s   = pc_r;
            end
            if (!halt_i) begin
               state_nxt_s    = ST_RUN;
               valid_nxt_s    = 1'b1;
               pc_epoch_nxt_s = cur_epoch_nxt_s;
            end else begin
               valid_nxt_s    = 1'b0;
            end
         end

         default: begin
            state_nxt_s = ST_BOOT;
            valid_nxt_s = 1'b0;
         end
      endcase
   end

   // State and output registers; reset discards any buffered redirect.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r     <= ST_BOOT;
         boot_cnt_r  <= {BOOT_W{1'b0}};
         valid_r     <= 1'b0;
         pc_r        <= RESET_PC;
         mask_r      <= MASK_ALL;
         pc_epoch_r  <= {EPOCH_W{1'b0}};
         cur_epoch_r <= {EPOCH_W{1'b0}};
         pend_r      <= 1'b0;
         pend_pc_r   <= {XLEN{1'b0}};
         pend_mask_r <= MASK_ALL;
      end else begin
         state_r     <= state_nxt_s;
         boot_cnt_r  <= boot_cnt_nxt_s;
         valid_r     <= valid_nxt_s;
         pc_r        <= pc_nxt_s;
         mask_r      <= mask_nxt_s;
         pc_epoch_r  <= pc_epoch_nxt_s;
         cur_epoch_r <= cur_epoch_nxt_s;
         pend_r      <= pend_nxt_s;
         pend_pc_r   <= pend_pc_nxt_s;
         pend_mask_r <= pend_mask_nxt_s;
      end
   end

   assign valid_o      = valid_r;
   assign pc_o         = pc_r;
   assign slot_mask_o  = mask_r;
   assign pc_epoch_o   = pc_epoch_r;
   assign cur_epoch_o  = cur_epoch_r;
   assign redir_pend_o = pend_r;

endmodule

// File: tb/tb_pcu_fetch_gen.sv
// -----------------------------------------------------------------------------
// tb_pcu_fetch_gen
// Directed bench for pcu_fetch_gen (default parameters). Expected fetch groups
// are queued up front; a negedge monitor pops and compares one entry on every
// handshake. Side-band outputs are checked directly between cycles.
// -----------------------------------------------------------------------------
module tb_pcu_fetch_gen;

   logic        clk;
   logic        reset_n;
   logic        ready_i;
   logic        halt_i;
   logic [1:0]  redir_valid_i;
   logic [63:0] redir_addr_i;
   logic        valid_o;
   logic [31:0] pc_o;
   logic [1:0]  slot_mask_o;
   logic [2:0]  pc_epoch_o;
   logic [2:0]  cur_epoch_o;
   logic        redir_pend_o;

   typedef struct {
      logic [31:0] pc;
      logic [2:0]  ep;
      logic [1:0]  mask;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk = 0;
   int   n_err = 0;

`ifdef PCU_ALIGN_EN
   localparam logic [31:0] A1 = 32'h0000_0108;
   localparam logic [1:0]  M1 = 2'b10;
   localparam logic [31:0] A2 = 32'h0000_0110;
`else
   localparam logic [31:0] A1 = 32'h0000_010C;
   localparam logic [1:0]  M1 = 2'b11;
   localparam logic [31:0] A2 = 32'h0000_0114;
`endif

   pcu_fetch_gen dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .ready_i       (ready_i),
      .halt_i        (halt_i),
      .redir_valid_i (redir_valid_i),
      .redir_addr_i  (redir_addr_i),
      .valid_o       (valid_o),
      .pc_o          (pc_o),
      .slot_mask_o   (slot_mask_o),
      .pc_epoch_o    (pc_epoch_o),
      .cur_epoch_o   (cur_epoch_o),
      .redir_pend_o  (redir_pend_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic push(input logic [31:0] pc, input logic [2:0] ep, input logic [1:0] mask);
      exp_t e;
      e.pc = pc; e.ep = ep; e.mask = mask;
      exp_q.push_back(e);
   endtask

   // Apply inputs for the current cycle, then move to just after the next edge.
   task automatic cyc(input logic r, input logic h, input logic [1:0] rv,
                      input logic [31:0] a0, input logic [31:0] a1);
      ready_i = r; halt_i = h; redir_valid_i = rv; redir_addr_i = {a1, a0};
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_valid"},  {31'd0, valid_o},      32'd0);
      chk({tag, "_pc"},     pc_o,                  32'd0);
      chk({tag, "_mask"},   {30'd0, slot_mask_o},  32'd3);
      chk({tag, "_pcep"},   {29'd0, pc_epoch_o},   32'd0);
      chk({tag, "_curep"},  {29'd0, cur_epoch_o},  32'd0);
      chk({tag, "_pend"},   {31'd0, redir_pend_o}, 32'd0);
   endtask

   // Scoreboard monitor: one expected group consumed per handshake.
   always @(negedge clk) begin
      if (reset_n && valid_o && ready_i) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL unexpected_group actual_pc=%h required=none", pc_o);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("grp_pc",   pc_o,                 e.pc);
            chk("grp_ep",   {29'd0, pc_epoch_o},  {29'd0, e.ep});
            chk("grp_mask", {30'd0, slot_mask_o}, {30'd0, e.mask});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      reset_n = 1'b0; ready_i = 1'b0; halt_i = 1'b0;
      redir_valid_i = 2'b00; redir_addr_i = 64'd0;

      push(32'h0,   3'd0, 2'b11);
      push(32'h8,   3'd0, 2'b11);
      push(32'h10,  3'd0, 2'b11);
      push(32'h18,  3'd0, 2'b11);
      push(32'h300, 3'd1, 2'b11);
      push(32'h200, 3'd2, 2'b11);
      push(32'h208, 3'd2, 2'b11);
      push(32'h500, 3'd4, 2'b11);
      push(32'h508, 3'd4, 2'b11);
      push(32'h600, 3'd5, 2'b11);
      push(32'h608, 3'd5, 2'b11);
      push(32'h610, 3'd5, 2'b11);
      push(32'h618, 3'd5, 2'b11);
      push(A1,      3'd6, M1);
      push(A2,      3'd6, 2'b11);
      push(32'hFFFF_FFF8, 3'd7, 2'b11);
      push(32'h0,   3'd7, 2'b11);

      repeat (2) @(posedge clk);
      #1;
      chk_reset_vals("rst");

      // Boot: one cycle low, then the reset PC.
      reset_n = 1'b1; ready_i = 1'b1;
      #1;
      chk("boot_valid_low", {31'd0, valid_o}, 32'd0);
      cyc(1'b1, 1'b0, 2'b00, 32'h0, 32'h0);
      chk("boot_valid_high", {31'd0, valid_o}, 32'd1);
      chk("boot_pc", pc_o, 32'h0);
      cyc(1'b1, 1'b0, 2'b00, 32'h0, 32'h0);
      cyc(1'b1, 1'b0, 2'b00, 32'h0, 32'h0);

      // Stall for three cycles at 0x10.
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
         chk("stall_pc", pc_o, 32'h10);
         chk("stall_valid", {31'd0, valid_o}, 32'd1);
      end
      cyc(1'b1, 1'b0, 2'b00, 32'h0, 32'h0);
      chk("resume_pc", pc_o, 32'h18);

      // Redirect while stalled at 0x18 is buffered.
      cyc(1'b0, 1'b0, 2'b01, 32'h300, 32'h0);
      chk("pend_hold_pc", pc_o, 32'h18);
      chk("pend_hold_ep", {29'd0, pc_epoch_o}, 32'd0);
      chk("pend_curep", {29'd0, cur_epoch_o}, 32'd1);
      chk("pend_set", {31'd0, redir_pend_o}, 32'd1);
      cyc(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
      chk("pend_still", {31'd0, redir_pend_o}, 32'd1);
      cyc(1'b1, 1'b0, 2'b00, 32'h0, 32'h0);
      chk("pend_issue_pc", pc_o, 32'h300);
      chk("pend_clear", {31'd0, redir_pend_o}, 32'd0);

      // Both sources during a handshake: source 1 wins.
      cyc(1'b1, 1'b0, 2'b11, 32'h100, 32'h200);
      chk("prio_pc", pc_o, 32'h200);
      chk("prio_curep", {29'd0, cur_epoch_o}, 32'd2);
      cyc(1'b1, 1'b0, 2'b00, 32'h0, 32'h0);

      // Two redirects while stalled: last one wins, epoch bumps twice.
      cyc(1'b0, 1'b0, 2'b01, 32'h400, 32'h0);
      cyc(1'b0, 1'b0, 2'b10, 32'h0, 32'h500);
      chk("lastwin_pend", {31'd0, redir_pend_o}, 32'd1);
      chk("lastwin_curep", {29'd0, cur_epoch_o}, 32'd4);
      cyc(1'b1, 1'b0, 2'b00, 32'h0, 32'h0);
      chk("lastwin_pc", pc_o, 32'h500);
      cyc(1'b1, 1'b0, 2'b00, 32'h0, 32'h0);

      // Halt after handshake; redirect during halt applies on restart.
      cyc(1'b1, 1'b1, 2'b00, 32'h0, 32'h0);
      chk("halt_valid", {31'd0, valid_o}, 32'd0);
      cyc(1'b1, 1'b1, 2'b01, 32'h600, 32'h0);
      chk("halt_valid2", {31'd0, valid_o}, 32'd0);
      chk("halt_curep", {29'd0, cur_epoch_o}, 32'd5);
      chk("halt_nopend", {31'd0, redir_pend_o}, 32'd0);
      cyc(1'b1, 1'b0, 2'b00, 32'h0, 32'h0);
      chk("unhalt_valid", {31'd0, valid_o}, 32'd1);
      chk("unhalt_pc", pc_o, 32'h600);
      cyc(1'b1, 1'b0, 2'b00, 32'h0, 32'h0);

      // Halt while stalled: held group completes first.
      cyc(1'b0, 1'b1, 2'b00, 32'h0, 32'h0);
      chk("halt_stall_valid", {31'd0, valid_o}, 32'd1);
      chk("halt_stall_pc", pc_o, 32'h608);
      cyc(1'b1, 1'b1, 2'b00, 32'h0, 32'h0);
      chk("halt_after_hs", {31'd0, valid_o}, 32'd0);
      cyc(1'b1, 1'b0, 2'b00, 32'h0, 32'h0);
      cyc(1'b1, 1'b0, 2'b00, 32'h0, 32'h0);

      // Misaligned redirect target.
      cyc(1'b1, 1'b0, 2'b01, 32'h10C, 32'h0);
      chk("align_pc", pc_o, A1);
      chk("align_mask", {30'd0, slot_mask_o}, {30'd0, M1});
      cyc(1'b1, 1'b0, 2'b00, 32'h0, 32'h0);
      chk("align_next_mask", {30'd0, slot_mask_o}, 32'd3);

      // Address wrap, then epoch wrap to 0.
      cyc(1'b1, 1'b0, 2'b01, 32'hFFFF_FFF8, 32'h0);
      cyc(1'b1, 1'b0, 2'b00, 32'h0, 32'h0);
      chk("wrap_pc", pc_o, 32'h0);
      cyc(1'b1, 1'b0, 2'b01, 32'h40, 32'h0);
      chk("epwrap_curep", {29'd0, cur_epoch_o}, 32'd0);
      chk("epwrap_pcep", {29'd0, pc_epoch_o}, 32'd0);

      // Reset mid-cycle with a pending redirect.
      cyc(1'b0, 1'b0, 2'b01, 32'h80, 32'h0);
      chk("prerst_pend", {31'd0, redir_pend_o}, 32'd1);
      chk("prerst_curep", {29'd0, cur_epoch_o}, 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      chk_reset_vals("midrst");
      @(posedge clk);
      #1;
      redir_valid_i = 2'b00;
      push(32'h0, 3'd0, 2'b11);
      reset_n = 1'b1;
      cyc(1'b1, 1'b0, 2'b00, 32'h0, 32'h0);
      chk("rerun_pc", pc_o, 32'h0);
      cyc(1'b1, 1'b0, 2'b00, 32'h0, 32'h0);
      chk("rerun_next_pc", pc_o, 32'h8);
      chk("rerun_pend", {31'd0, redir_pend_o}, 32'd0);
      cyc(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);

      chk("queue_drained", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
